// File: rtl/parallel_adder_selftest_pkg.sv
// Package: adder_selftest_pkg
// Shared definitions for the parallel-adder self-test block.
//   state_t      : controller states (IDLE, DRIVE, WAIT, CHECK, DONE)
//   WIDTH_DEF    : default adder operand width
//   VEC_W        : width of one test vector {A,B,Cin} at the default width
//   NUM_VEC      : number of distinct vectors at the default width
//   ERR_MAX      : saturation value of the mismatch counter
//   lfsr_taps()  : maximal-length Fibonacci tap mask for a given register width
//   LFSR_TAPS    : tap mask for the default vector width
package adder_selftest_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int WIDTH_DEF = 3;
  localparam int VEC_W     = 2 * WIDTH_DEF + 1;
  localparam int NUM_VEC   = 1 << VEC_W;
  localparam int ERR_MAX   = 255;

  // Tap masks are for a left-shifting register whose new LSB is the XOR of
  // the masked bits; each entry is a known maximal-length polynomial. Only
  // odd widths appear because the vector width is always 2*WIDTH+1.
  function automatic logic [31:0] lfsr_taps(input int w);
    logic [31:0] taps;
    taps = 32'h0000_0060;
    case (w)
      3:       taps = 32'h0000_0006;
      5:       taps = 32'h0000_0014;
      7:       taps = 32'h0000_0060;
      9:       taps = 32'h0000_0110;
      11:      taps = 32'h0000_0500;
      13:      taps = 32'h0000_1C80;
      15:      taps = 32'h0000_6000;
      default: taps = 32'h0000_0060;
    endcase
    return taps;
  endfunction

  localparam logic [31:0] LFSR_TAPS = lfsr_taps(VEC_W);

endpackage

// File: rtl/parallel_adder_selftest_lfsr.sv
// Module: selftest_lfsr
// Pseudo-random vector source for the adder self-test. Only compiled when
// SELFTEST_LFSR_EN is defined; the exhaustive build needs no LFSR at all.
// Ports:
//   clk   in   clock
//   rst   in   asynchronous active-low reset (register returns to the seed)
//   load  in   reload the seed value 1
//   step  in   advance one state
//   q     out  current state, never all-zero
`ifdef SELFTEST_LFSR_EN
module selftest_lfsr
  import adder_selftest_pkg::*;
#(
  parameter int          W    = VEC_W,
  parameter logic [31:0] TAPS = lfsr_taps(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  output logic [W-1:0] q
);

  logic feedback;

  // Feedback is the parity of the tapped bits; it enters at the LSB.
  always_comb begin
    feedback = ^(q & TAPS[W-1:0]);
  end

  // Seed 1 on reset and on load so every run starts from the same sequence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= W'(1);
    end else if (load) begin
      q <= W'(1);
    end else if (step) begin
      q <= {q[W-2:0], feedback};
    end
  end

endmodule
`endif

// File: rtl/parallel_adder_selftest.sv
// Module: parallel_adder_selftest
// On-chip stimulus generator and checker for a WIDTH-bit parallel adder.
// It drives {A,B,Cin}, waits SETTLE_CYCLES, samples {Cout,Sum}, compares
// against A+B+Cin and counts mismatches, remembering the first bad vector.
// Build option: define SELFTEST_LFSR_EN to take vectors from a maximal LFSR
// (seed 1, zero vector skipped); otherwise vectors are the index itself.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   start      in   level, starts a run from IDLE or DONE
//   A, B       out  operands to the adder (WIDTH bits)
//   Cin        out  carry-in to the adder
//   Sum, Cout  in   adder result
//   busy       out  high in DRIVE/WAIT/CHECK
//   done       out  high in DONE
//   pass       out  in DONE: no mismatches seen
//   err_count  out  saturating mismatch count
//   fail_vec   out  {A,B,Cin} of the first mismatch, 0 if none
module parallel_adder_selftest
  import adder_selftest_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_COUNT     = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             Cin,
  input  logic [WIDTH-1:0] Sum,
  input  logic             Cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [2*WIDTH:0] fail_vec
);

  localparam int VW = 2 * WIDTH + 1;
  localparam int NV = 1 << VW;
`ifdef SELFTEST_LFSR_EN
  localparam int RUN_CAP = NV - 1;
`else
  localparam int RUN_CAP = NV;
`endif
  localparam int            RUN_LEN  = (MAX_COUNT < RUN_CAP) ? MAX_COUNT : RUN_CAP;
  localparam logic [VW-1:0] LAST_IDX = VW'(RUN_LEN - 1);
  localparam logic [3:0]    SETTLE   = 4'(SETTLE_CYCLES);
  localparam logic [7:0]    ERR_SAT  = 8'(ERR_MAX);

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      settle_cnt;
  logic [VW-1:0]   idx;
  logic [VW-1:0]   vec_src;
  logic            first_fail;
  logic            start_run;
  logic            last_vec;
  logic            mismatch;
  logic [WIDTH:0]  expected;
  logic [WIDTH:0]  observed;

  // A run may only begin from a quiescent state; start while busy is ignored.
  always_comb begin
    start_run = start && ((state == IDLE) || (state == DONE));
    last_vec  = (idx == LAST_IDX);
  end

  // The reference sum is formed one bit wider so the carry is compared too.
  always_comb begin
    expected = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
    observed = {Cout, Sum};
    mismatch = (observed != expected);
  end

`ifdef SELFTEST_LFSR_EN
  // The LFSR reloads its seed at the start of every run and advances only
  // when another vector is about to be driven.
  logic [VW-1:0] lfsr_q;

  selftest_lfsr #(
    .W    (VW),
    .TAPS (lfsr_taps(VW))
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (start_run),
    .step ((state == CHECK) && !last_vec),
    .q    (lfsr_q)
  );

  always_comb begin
    vec_src = lfsr_q;
  end
`else
  // Exhaustive mode: the vector is simply the index in binary order.
  always_comb begin
    vec_src = idx;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; the CHECK state decides between another vector and DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   state_nxt = WAIT;
      WAIT:    if (settle_cnt == 4'd1) state_nxt = CHECK;
      CHECK:   state_nxt = last_vec ? DONE : DRIVE;
      DONE:    if (start) state_nxt = DRIVE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand registers, settle counter, vector index and the
  // mismatch bookkeeping. Operands are left alone in DONE so the last vector
  // stays visible until the next run drives a new one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      A          <= '0;
      B          <= '0;
      Cin        <= 1'b0;
      settle_cnt <= '0;
      idx        <= '0;
      err_count  <= '0;
      fail_vec   <= '0;
      first_fail <= 1'b0;
    end else begin
      if (start_run) begin
        idx        <= '0;
        err_count  <= '0;
        fail_vec   <= '0;
        first_fail <= 1'b0;
      end
      case (state)
        DRIVE: begin
          {A, B, Cin} <= vec_src;
          settle_cnt  <= SETTLE;
        end
        WAIT: begin
          settle_cnt <= settle_cnt - 4'd1;
        end
        CHECK: begin
          if (mismatch) begin
            if (err_count != ERR_SAT) begin
              err_count <= err_count + 8'd1;
            end
            if (!first_fail) begin
              fail_vec   <= {A, B, Cin};
              first_fail <= 1'b1;
            end
          end
          if (!last_vec) begin
            idx <= idx + VW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Status flags decode straight from the state register.
  always_comb begin
    busy = (state == DRIVE) || (state == WAIT) || (state == CHECK);
    done = (state == DONE);
    pass = (state == DONE) && (err_count == 8'd0);
  end

endmodule
